ctrl_intersection: RTL and testbench
====================================

CTRL_INTERSECTION -- requirements
Module: ctrl_intersection

Interface
REQ-001 Parameter N_APPR, default 2, number of approaches served, legal range 2..8.
REQ-002 Parameter T_GREEN, default 8, green duration in ticks, minimum 1.
REQ-003 Parameter T_YELLOW, default 2, yellow duration in ticks (used before and after green), minimum 1.
REQ-004 Parameter T_ALLRED, default 1, all-red clearance duration in ticks, minimum 1.
REQ-005 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 Port res_n  input  1  reset, asynchronous, active-low.
REQ-007 Port tick  input  1  single-cycle time-base strobe; durations count ticks.
REQ-008 Port req  input  N_APPR  per-approach service request (button or detector), level or pulse.
REQ-009 Port rgb  output  N_APPR x 3  per-approach lamp: red 100, yellow 110, green 010.
REQ-010 Port active  output  clog2(N_APPR), minimum 1  index of the approach currently served; 0 when idle.
REQ-011 Port idle  output  1  high while in ALLRED with no pending request.

Function
REQ-012 FSM states: ALLRED, PREYEL, GREEN, POSTYEL; one phase counter shared by all states.
REQ-013 Counter resets to 0 on every state entry; a state exits on the tick for which counter == duration-1, otherwise increments on tick.
REQ-014 Each req bit sets a sticky pending bit on the cycle it is high; pending of approach i clears on the cycle PREYEL for i is entered.
REQ-015 A req for the approach being served, arriving during PREYEL/GREEN/POSTYEL, sets pending again and is served in a later round.
REQ-016 ALLRED exits only if counter has expired and any pending bit is set; otherwise it stays in ALLRED with the counter saturated.
REQ-017 On ALLRED exit, the next approach is chosen round-robin: the first pending index strictly after the last served, wrapping modulo N_APPR.
REQ-018 Transitions: ALLRED -> PREYEL -> GREEN -> POSTYEL -> ALLRED; no phase is skipped.
REQ-019 rgb: served approach shows 110 in PREYEL/POSTYEL and 010 in GREEN; every other approach, and all approaches in ALLRED, show 100.
REQ-020 rgb and active are decoded from registered state; a transition on tick at edge k is visible after edge k.
REQ-021 When req and the exit tick coincide, the request is latched and also considered for the same arbitration.
REQ-022 At no time does more than one approach show a non-red lamp.

Reset
REQ-023 While res_n is low: state ALLRED, counter saturated (immediately eligible to exit), pending all 0, last-served = N_APPR-1, rgb all 100, active 0, idle 1.
REQ-024 Reset asserted mid-phase forces all-red asynchronously; pending requests are discarded.

Configuration
REQ-025 Macro CTRL_INTERSECTION_WALK_EN: when defined, adds output walk (N_APPR bits), high for approach i only while i is in GREEN and counter < T_GREEN-1, and low in the last green tick interval.
REQ-026 Without CTRL_INTERSECTION_WALK_EN the walk port and its logic are absent; all other behaviour is identical.

Structure
REQ-027 Package ctrl_pkg holds the phase enum (ALLRED, PREYEL, GREEN, POSTYEL) and the lamp constants RGB_RED, RGB_YELLOW, RGB_GREEN.
REQ-028 Sub-module rr_arbiter (N parameter; inputs pending and last index; output next index and a valid flag) holds the round-robin selection.

Verification
REQ-029 Defaults; no req, 20 ticks -> rgb stays 100/100, idle 1.
REQ-030 Defaults; req[1] pulse, then ticks -> approach 1 shows 110 for 2 ticks, 010 for 8, 110 for 2, then 100; approach 0 stays 100 throughout.
REQ-031 req = 2'b11 together -> approach 0 served first, then approach 1 after 1 all-red tick.
REQ-032 N_APPR=4; pending {0,2,3}, last served 2 -> order 3, 0, 2.
REQ-033 res_n low during GREEN of approach 1 -> all rgb 100 without waiting for a clock edge; pending cleared; after release, no service without a new req.
REQ-034 WALK_EN defined, defaults -> walk[i] high for 7 ticks of i's 8-tick green, low otherwise.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and constants for the ctrl_intersection traffic
//               light controller: phase encoding, lamp codes and width helpers.
//               Optional feature macro: CTRL_INTERSECTION_WALK_EN
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Controller phases, in the order they are visited for every service round
  typedef enum logic [1:0] {
    ALLRED  = 2'd0,
    PREYEL  = 2'd1,
    GREEN   = 2'd2,
    POSTYEL = 2'd3
  } phase_t;

  // Lamp encodings, one 3-bit {red, yellow, green} group per approach
  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_GREEN  = 3'b010;

  // Width of an approach index; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width of the shared phase counter, sized for the longest phase
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_intersection_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_intersection_if
// Description : Request/lamp bundle between the intersection controller and
//               its environment. The walk signal exists only when
//               CTRL_INTERSECTION_WALK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_intersection_if #(
  parameter int N_APPR = 2
) ();

  localparam int IW = ctrl_pkg::idx_width(N_APPR);

  logic                   tick;
  logic [N_APPR-1:0]      req;
  logic [N_APPR-1:0][2:0] rgb;
  logic [IW-1:0]          active;
  logic                   idle;
`ifdef CTRL_INTERSECTION_WALK_EN
  logic [N_APPR-1:0]      walk;

  modport master (output tick, output req, input rgb, input active, input idle, input walk);
  modport slave  (input tick, input req, output rgb, output active, output idle, output walk);
`else
  modport master (output tick, output req, input rgb, input active, input idle);
  modport slave  (input tick, input req, output rgb, output active, output idle);
`endif

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin pick of the first pending index strictly after
//               the last served one, wrapping modulo N. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import ctrl_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] next,
  output logic          valid
);

  // Scan from the farthest candidate to the nearest so the nearest one wins
  always_comb begin
    next  = '0;
    valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(last) + k) % N);
      if (pending[cand]) begin
        next  = cand;
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_intersection.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_intersection
// Description : Round-robin traffic light controller. Each served approach
//               runs PREYEL -> GREEN -> POSTYEL, separated by an ALLRED
//               clearance. Requests are sticky until their round starts.
//               Optional feature macro: CTRL_INTERSECTION_WALK_EN adds a
//               per-approach walk output during all but the last green tick.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_intersection
  import ctrl_pkg::*;
#(
  parameter int N_APPR   = 2,
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 2,
  parameter int T_ALLRED = 1
) (
  input logic               clk,
  input logic               res_n,
  ctrl_intersection_if.slave bus
);

  localparam int IW = idx_width(N_APPR);
  localparam int CW = cnt_width(T_GREEN, T_YELLOW, T_ALLRED);

  localparam logic [CW-1:0] GREEN_M1  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_M1 = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_M1 = CW'(T_ALLRED - 1);

  phase_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [CW-1:0]          dur_m1;
  logic                   expired;
  logic [N_APPR-1:0]      pending, pending_nxt, pend_all;
  logic [IW-1:0]          served, served_nxt;
  logic [IW-1:0]          pick;
  logic                   pick_valid;
  logic [N_APPR-1:0][2:0] rgb_nxt;
  logic [IW-1:0]          active_nxt;
  logic                   idle_nxt;
`ifdef CTRL_INTERSECTION_WALK_EN
  logic [N_APPR-1:0]      walk_nxt;
`endif

  // Requests arriving this cycle take part in the same arbitration
  assign pend_all = pending | bus.req;

  rr_arbiter #(
    .N (N_APPR)
  ) u_arb (
    .pending (pend_all),
    .last    (served),
    .next    (pick),
    .valid   (pick_valid)
  );

  // Terminal count of the current phase
  always_comb begin
    dur_m1 = ALLRED_M1;
    case (state)
      PREYEL, POSTYEL: dur_m1 = YELLOW_M1;
      GREEN:           dur_m1 = GREEN_M1;
      default:         dur_m1 = ALLRED_M1;
    endcase
  end

  assign expired = (cnt == dur_m1);

  // Phase sequencing; the counter restarts on entry and advances on tick only
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    served_nxt  = served;
    pending_nxt = pend_all;
    if (bus.tick) begin
      case (state)
        ALLRED: begin
          if (!expired) begin
            cnt_nxt = cnt + CW'(1);
          end else if (pick_valid) begin
            state_nxt         = PREYEL;
            cnt_nxt           = '0;
            served_nxt        = pick;
            pending_nxt[pick] = 1'b0;
          end
        end
        PREYEL: begin
          if (expired) begin
            state_nxt = GREEN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        GREEN: begin
          if (expired) begin
            state_nxt = POSTYEL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        POSTYEL: begin
          if (expired) begin
            state_nxt = ALLRED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = ALLRED;
          cnt_nxt   = ALLRED_M1;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the registered lamps track it exactly
  always_comb begin
    rgb_nxt    = '0;
    active_nxt = '0;
    idle_nxt   = (state_nxt == ALLRED) && (pending_nxt == '0);
`ifdef CTRL_INTERSECTION_WALK_EN
    walk_nxt   = '0;
`endif
    if (state_nxt != ALLRED) begin
      active_nxt = served_nxt;
    end
    for (int i = 0; i < N_APPR; i++) begin
      rgb_nxt[i] = RGB_RED;
      if ((state_nxt != ALLRED) && (served_nxt == IW'(i))) begin
        rgb_nxt[i] = (state_nxt == GREEN) ? RGB_GREEN : RGB_YELLOW;
      end
`ifdef CTRL_INTERSECTION_WALK_EN
      walk_nxt[i] = (state_nxt == GREEN) && (served_nxt == IW'(i)) && (cnt_nxt < GREEN_M1);
`endif
    end
  end

  // State, counter, pending set and registered lamp outputs
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= ALLRED;
      cnt        <= ALLRED_M1;
      pending    <= '0;
      served     <= IW'(N_APPR - 1);
      bus.active <= '0;
      bus.idle   <= 1'b1;
      for (int i = 0; i < N_APPR; i++) begin
        bus.rgb[i] <= RGB_RED;
      end
`ifdef CTRL_INTERSECTION_WALK_EN
      bus.walk   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      served     <= served_nxt;
      bus.rgb    <= rgb_nxt;
      bus.active <= active_nxt;
      bus.idle   <= idle_nxt;
`ifdef CTRL_INTERSECTION_WALK_EN
      bus.walk   <= walk_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_intersection.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_intersection
// Description : Self-checking bench for ctrl_intersection. A 2-approach and a
//               4-approach instance share clock, reset and tick. Expected lamp
//               frames are queued as requests are issued and compared after
//               every tick. Walk is checked when CTRL_INTERSECTION_WALK_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_intersection;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b110;
  localparam logic [2:0] GRN = 3'b010;
  localparam int TG = 8;
  localparam int TY = 2;
`ifdef CTRL_INTERSECTION_WALK_EN
  localparam bit WALK_ON = 1'b1;
`else
  localparam bit WALK_ON = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] rgb;
    logic [1:0]  act;
    logic        idle;
    logic [3:0]  walk;
  } frame_t;

  logic clk = 1'b0;
  logic res_n;
  int   ncmp = 0;
  int   nfail = 0;
  frame_t q2[$];
  frame_t q4[$];

  always #5 clk = ~clk;

  ctrl_intersection_if #(.N_APPR(2)) bus2 ();
  ctrl_intersection_if #(.N_APPR(4)) bus4 ();

  ctrl_intersection #(.N_APPR(2)) dut2 (.clk(clk), .res_n(res_n), .bus(bus2.slave));
  ctrl_intersection #(.N_APPR(4)) dut4 (.clk(clk), .res_n(res_n), .bus(bus4.slave));

  // Build an expected frame: approach idx shows code, all others red
  function automatic frame_t mk(input int n, input int idx, input logic [2:0] code,
                                input logic idl, input logic wk);
    frame_t f;
    f = '0;
    for (int i = 0; i < n; i++) f.rgb[i*3 +: 3] = (i == idx) ? code : RED;
    f.act  = (code == RED) ? 2'd0 : 2'(idx);
    f.idle = idl;
    if (wk && WALK_ON) f.walk[idx] = 1'b1;
    return f;
  endfunction

  function automatic frame_t obs2();
    frame_t f;
    f = '0;
    f.rgb  = 12'(bus2.rgb);
    f.act  = 2'(bus2.active);
    f.idle = bus2.idle;
`ifdef CTRL_INTERSECTION_WALK_EN
    f.walk = 4'(bus2.walk);
`endif
    return f;
  endfunction

  function automatic frame_t obs4();
    frame_t f;
    f = '0;
    f.rgb  = 12'(bus4.rgb);
    f.act  = bus4.active;
    f.idle = bus4.idle;
`ifdef CTRL_INTERSECTION_WALK_EN
    f.walk = bus4.walk;
`endif
    return f;
  endfunction

  task automatic check2(input string tag, input frame_t e);
    frame_t o;
    o = obs2();
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s dut2 observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check4(input string tag, input frame_t e);
    frame_t o;
    o = obs4();
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s dut4 observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Queue the frames of one full service round, followed by the all-red frame
  task automatic push_svc(input int n, input int idx, input bit more);
    frame_t f;
    for (int k = 0; k < TY; k++) begin f = mk(n, idx, YEL, 1'b0, 1'b0); if (n == 2) q2.push_back(f); else q4.push_back(f); end
    for (int k = 0; k < TG; k++) begin f = mk(n, idx, GRN, 1'b0, k < TG - 1); if (n == 2) q2.push_back(f); else q4.push_back(f); end
    for (int k = 0; k < TY; k++) begin f = mk(n, idx, YEL, 1'b0, 1'b0); if (n == 2) q2.push_back(f); else q4.push_back(f); end
    f = mk(n, 0, RED, !more, 1'b0);
    if (n == 2) q2.push_back(f); else q4.push_back(f);
  endtask

  task automatic pop_check();
    if (q2.size() > 0) check2("seq2", q2.pop_front());
    if (q4.size() > 0) check4("seq4", q4.pop_front());
  endtask

  // One tick strobe, optionally carrying requests in the same cycle
  task automatic tick_req(input logic [1:0] r2, input logic [3:0] r4);
    @(negedge clk);
    bus2.tick = 1'b1; bus4.tick = 1'b1;
    bus2.req  = r2;   bus4.req  = r4;
    @(negedge clk);
    bus2.tick = 1'b0; bus4.tick = 1'b0;
    bus2.req  = '0;   bus4.req  = '0;
    pop_check();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_req(2'b00, 4'b0000);
  endtask

  task automatic pulse(input logic [1:0] r2, input logic [3:0] r4);
    @(negedge clk);
    bus2.req = r2; bus4.req = r4;
    @(negedge clk);
    bus2.req = '0; bus4.req = '0;
  endtask

  initial begin
    res_n = 1'b0;
    bus2.tick = 1'b0; bus2.req = '0;
    bus4.tick = 1'b0; bus4.req = '0;
    repeat (3) @(negedge clk);
    check2("reset", mk(2, 0, RED, 1'b1, 1'b0));
    check4("reset", mk(4, 0, RED, 1'b1, 1'b0));
    res_n = 1'b1;
    @(negedge clk);

    // No requests: stays all red and idle
    for (int i = 0; i < 20; i++) q2.push_back(mk(2, 0, RED, 1'b1, 1'b0));
    ticks(20);

    // Single request on approach 1
    pulse(2'b10, 4'b0000);
    check2("pending_not_idle", mk(2, 0, RED, 1'b0, 1'b0));
    push_svc(2, 1, 1'b0);
    ticks(13);

    // Both approaches at once: 0 first (wrap after 1), then 1
    pulse(2'b11, 4'b0000);
    push_svc(2, 0, 1'b1);
    push_svc(2, 1, 1'b0);
    ticks(26);

    // Request coinciding with the exit tick is served by that tick
    push_svc(2, 0, 1'b0);
    tick_req(2'b01, 4'b0000);
    ticks(12);

    // Reset in the green of approach 1 with a re-request pending
    pulse(2'b10, 4'b0000);
    push_svc(2, 1, 1'b0);
    ticks(5);
    pulse(2'b10, 4'b0000);
    @(negedge clk);
    #2 res_n = 1'b0;
    #1;
    check2("async_reset", mk(2, 0, RED, 1'b1, 1'b0));
    check4("async_reset", mk(4, 0, RED, 1'b1, 1'b0));
    q2.delete();
    @(negedge clk);
    res_n = 1'b1;
    for (int i = 0; i < 5; i++) q2.push_back(mk(2, 0, RED, 1'b1, 1'b0));
    ticks(5);

    // Four approaches: serve 2, then pending {0,2,3} -> order 3, 0, 2
    pulse(2'b00, 4'b0100);
    push_svc(4, 2, 1'b1);
    push_svc(4, 3, 1'b1);
    push_svc(4, 0, 1'b1);
    push_svc(4, 2, 1'b0);
    ticks(5);
    pulse(2'b00, 4'b1101);
    ticks(47);
    ticks(3);

    ncmp++;
    assert (q2.size() == 0 && q4.size() == 0) else begin
      nfail++;
      $error("FAIL queues_drained observed=%0d/%0d expected=0/0", q2.size(), q4.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
